// File: rtl/cariomart_pkg.sv
// Shared constants, state encodings and the tick-divider helper for the
// cariomart UART command receiver.
package cariomart_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        F_SYNC,
        F_CMD,
        F_ARG,
        F_CHK
    } frm_state_t;

    // Clocks per oversampling tick, truncated; callers rely on the result being >= 2.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/cariomart_uart_rx.sv
// 16x-oversampled 8N1 receiver: rxd synchroniser, free-running tick divider
// and bit-level FSM. byte_strobe and frame_err are single-cycle decodes of
// the stop-bit sample cycle, so the framer reacts in that same cycle.
module cariomart_uart_rx
    import cariomart_pkg::*;
#(
    parameter int CLK_HZ = 40_000_000,
    parameter int BAUD   = 57_600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_err
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int DIV_W = $clog2(DIV);

    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;
    rx_state_t        state_q, state_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value; blocking here would collapse the chain.
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Free-running divider producing a one-cycle tick every DIV clocks.
    always_comb begin
        // NOTE: every combinational output gets a value on all paths, otherwise a latch is inferred.
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    // Bit FSM next-state: mid-bit sampling at 8 ticks into start, then every 16 ticks.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_strobe = 1'b0;
        frame_err   = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (!rxd_sync_q && rxd_prev_q) begin
                    state_d    = R_START;
                    tick_cnt_d = '0;
                end
            end
            R_START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        // A high line at mid-start is a glitch, not a character.
                        state_d    = rxd_sync_q ? R_IDLE : R_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            R_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxd_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = R_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            R_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d  = '0;
                        state_d     = R_IDLE;
                        byte_strobe = rxd_sync_q;
                        frame_err   = !rxd_sync_q;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Divider and bit FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            state_q    <= R_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/cariomart_uart_cmd_rx.sv
// Packet framer, checksum check and depth-1 command holding register on top
// of cariomart_uart_rx. Packets are {0xA5, CMD, ARG, CMD^ARG}.
// Optional macro CARIOMART_RX_TIMEOUT_EN: resync the framer after
// TIMEOUT_BITS idle bit periods mid-packet.
module cariomart_uart_cmd_rx
    import cariomart_pkg::*;
#(
    parameter int CLK_HZ       = 40_000_000,
    parameter int BAUD         = 57_600,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic       FAB_CLK,
    input  logic       MSS_RESET_N,
    input  logic       rxd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_err,
    output logic       chk_err,
    output logic       overrun
);

    logic [7:0] rx_byte;
    logic       byte_strobe;
    logic       rx_frame_err;
    logic       timeout_hit;
    logic       pkt_done;

    frm_state_t frm_q, frm_d;
    logic [7:0] cmd_lat_q, cmd_lat_d;
    logic [7:0] arg_lat_q, arg_lat_d;
    logic       valid_q, valid_d;
    logic [7:0] code_q, code_d;
    logic [7:0] arg_q, arg_d;
    logic       chk_err_q, chk_err_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q;

    cariomart_uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk         (FAB_CLK),
        .rst_n       (MSS_RESET_N),
        .rxd         (rxd),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .frame_err   (rx_frame_err)
    );

`ifdef CARIOMART_RX_TIMEOUT_EN
    localparam int BIT_CLKS  = calc_div(CLK_HZ, BAUD) * OVERSAMPLE;
    localparam int BCLK_W    = $clog2(BIT_CLKS);
    localparam int BITS_W    = $clog2(TIMEOUT_BITS + 1);

    logic [BCLK_W-1:0] bit_clk_q, bit_clk_d;
    logic [BITS_W-1:0] bit_cnt_q, bit_cnt_d;

    // Bit-period counter since the last byte; saturates at the limit so it never wraps.
    always_comb begin
        bit_clk_d = bit_clk_q;
        bit_cnt_d = bit_cnt_q;
        if (byte_strobe) begin
            bit_clk_d = '0;
            bit_cnt_d = '0;
        end else if (bit_cnt_q != BITS_W'(TIMEOUT_BITS)) begin
            if (bit_clk_q == BCLK_W'(BIT_CLKS - 1)) begin
                bit_clk_d = '0;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
                bit_clk_d = bit_clk_q + 1'b1;
            end
        end
        timeout_hit = (bit_cnt_q == BITS_W'(TIMEOUT_BITS)) && (frm_q != F_SYNC);
    end

    // Idle-timeout counter registers.
    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            bit_clk_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            bit_clk_q <= bit_clk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Framer: walks SYNC/CMD/ARG/CHK on each received byte; a framing error or timeout resyncs.
    always_comb begin
        frm_d     = frm_q;
        cmd_lat_d = cmd_lat_q;
        arg_lat_d = arg_lat_q;
        pkt_done  = 1'b0;
        chk_err_d = 1'b0;
        if (rx_frame_err) begin
            frm_d = F_SYNC;
        end else if (byte_strobe) begin
            unique case (frm_q)
                F_SYNC: if (rx_byte == SYNC_BYTE) frm_d = F_CMD;
                F_CMD: begin
                    cmd_lat_d = rx_byte;
                    frm_d     = F_ARG;
                end
                F_ARG: begin
                    arg_lat_d = rx_byte;
                    frm_d     = F_CHK;
                end
                F_CHK: begin
                    if (rx_byte == (cmd_lat_q ^ arg_lat_q)) pkt_done  = 1'b1;
                    else                                    chk_err_d = 1'b1;
                    frm_d = F_SYNC;
                end
                default: frm_d = F_SYNC;
            endcase
        end else if (timeout_hit) begin
            frm_d = F_SYNC;
        end
    end

    // Holding register: load when empty or being drained this cycle, otherwise flag overrun.
    always_comb begin
        valid_d   = valid_q;
        code_d    = code_q;
        arg_d     = arg_q;
        overrun_d = 1'b0;
        if (pkt_done) begin
            if (!valid_q || cmd_ready) begin
                valid_d = 1'b1;
                code_d  = cmd_lat_q;
                arg_d   = arg_lat_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && cmd_ready) begin
            valid_d = 1'b0;
        end
    end

    // Framer, holding register and registered error pulses.
    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            frm_q       <= F_SYNC;
            cmd_lat_q   <= '0;
            arg_lat_q   <= '0;
            valid_q     <= 1'b0;
            // NOTE: the held command is data, but it drives outputs that must read 0 after reset, so it is reset too.
            code_q      <= '0;
            arg_q       <= '0;
            chk_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frm_q       <= frm_d;
            cmd_lat_q   <= cmd_lat_d;
            arg_lat_q   <= arg_lat_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            arg_q       <= arg_d;
            chk_err_q   <= chk_err_d;
            overrun_q   <= overrun_d;
            frame_err_q <= rx_frame_err;
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_code  = code_q;
    assign cmd_arg   = arg_q;
    assign chk_err   = chk_err_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cariomart_uart_cmd_rx.sv
// Directed bench for cariomart_uart_cmd_rx. Runs with DIV = 4 (64 clocks per
// bit). Expectations for the idle-gap scenario follow CARIOMART_RX_TIMEOUT_EN.
module tb_cariomart_uart_cmd_rx;

    localparam int CLK_HZ = 3_686_400;
    localparam int BAUD   = 57_600;
    localparam int BIT    = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       cmd_ready;
    logic       ready_drv;
    logic       chk_gate;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_err;
    logic       chk_err;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;
    int n_frame = 0;
    int n_chk = 0;
    int n_ovr = 0;
    int excl_bad = 0;

    always #5 clk = ~clk;

    // Ready is either driven directly, or raised only in the cycle a byte completes.
    assign cmd_ready = ready_drv | (chk_gate & dut.byte_strobe);

    cariomart_uart_cmd_rx #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (40)
    ) dut (
        .FAB_CLK     (clk),
        .MSS_RESET_N (rst_n),
        .rxd         (rxd),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_arg     (cmd_arg),
        .frame_err   (frame_err),
        .chk_err     (chk_err),
        .overrun     (overrun)
    );

    // Pulse counters (cycles high) and mutual-exclusion tracking.
    always @(negedge clk) begin
        if (frame_err) n_frame++;
        if (chk_err)   n_chk++;
        if (overrun)   n_ovr++;
        if (32'(frame_err) + 32'(chk_err) + 32'(overrun) > 1) excl_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        send_byte(8'hA5, 1'b1);
        send_byte(c, 1'b1);
        send_byte(a, 1'b1);
        send_byte(k, 1'b1);
    endtask

    task automatic consume(input string tag);
        @(negedge clk) ready_drv = 1'b1;
        @(negedge clk) ready_drv = 1'b0;
        check(tag, 32'(cmd_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        rxd       = 1'b1;
        ready_drv = 1'b0;
        chk_gate  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_code",  32'(cmd_code),  32'd0);
        check("rst_arg",   32'(cmd_arg),   32'd0);
        check("rst_errs",  {29'd0, frame_err, chk_err, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);

        // 1: good packet held while ready is low, then a one-cycle accept
        send_pkt(8'h10, 8'h7F, 8'h6F);
        check("t1_valid", 32'(cmd_valid), 32'd1);
        check("t1_code",  32'(cmd_code),  32'h10);
        check("t1_arg",   32'(cmd_arg),   32'h7F);
        repeat (100) @(negedge clk);
        check("t1_held", 32'(cmd_valid), 32'd1);
        consume("t1_drop");

        // 2: bad checksum, then a good packet
        send_pkt(8'h10, 8'h7F, 8'h00);
        check("t2_chk",    32'(n_chk),     32'd1);
        check("t2_novalid", 32'(cmd_valid), 32'd0);
        send_pkt(8'h01, 8'h02, 8'h03);
        check("t2_valid", 32'(cmd_valid), 32'd1);
        check("t2_code",  32'(cmd_code),  32'h01);
        check("t2_arg",   32'(cmd_arg),   32'h02);
        consume("t2_drop");

        // 3: leading garbage, 0xA5 as ARG data
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_pkt(8'h22, 8'hA5, 8'h87);
        check("t3_valid", 32'(cmd_valid), 32'd1);
        check("t3_code",  32'(cmd_code),  32'h22);
        check("t3_arg",   32'(cmd_arg),   32'hA5);
        check("t3_chk",   32'(n_chk),     32'd1);
        consume("t3_drop");

        // 4: framing error in the CMD slot resyncs the framer
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b0);
        check("t4_frame",   32'(n_frame),   32'd1);
        check("t4_novalid", 32'(cmd_valid), 32'd0);
        send_pkt(8'h33, 8'h44, 8'h77);
        check("t4_valid", 32'(cmd_valid), 32'd1);
        check("t4_code",  32'(cmd_code),  32'h33);
        check("t4_arg",   32'(cmd_arg),   32'h44);
        check("t4_chk",   32'(n_chk),     32'd1);
        consume("t4_drop");

        // 5a: second packet while the first is held and not accepted
        send_pkt(8'h11, 8'h22, 8'h33);
        send_pkt(8'h44, 8'h55, 8'h11);
        check("t5_ovr",   32'(n_ovr),     32'd1);
        check("t5_valid", 32'(cmd_valid), 32'd1);
        check("t5_code",  32'(cmd_code),  32'h11);
        check("t5_arg",   32'(cmd_arg),   32'h22);
        // 5b: ready only in the completion cycle replaces the held command
        send_byte(8'hA5, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        check("t5_pre_code", 32'(cmd_code), 32'h11);
        chk_gate = 1'b1;
        send_byte(8'h11, 1'b1);
        chk_gate = 1'b0;
        check("t5b_valid", 32'(cmd_valid), 32'd1);
        check("t5b_code",  32'(cmd_code),  32'h66);
        check("t5b_arg",   32'(cmd_arg),   32'h77);
        check("t5b_ovr",   32'(n_ovr),     32'd1);
        consume("t5_drop");

        // 6: long idle gap mid-packet
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (50 * BIT) @(negedge clk);
        send_pkt(8'h05, 8'h06, 8'h03);
`ifdef CARIOMART_RX_TIMEOUT_EN
        check("t6_valid", 32'(cmd_valid), 32'd1);
        check("t6_code",  32'(cmd_code),  32'h05);
        check("t6_arg",   32'(cmd_arg),   32'h06);
        check("t6_chk",   32'(n_chk),     32'd1);
`else
        check("t6_valid", 32'(cmd_valid), 32'd0);
        check("t6_chk",   32'(n_chk),     32'd2);
`endif

        // 7: reset in the middle of the ARG byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        @(negedge clk) rxd = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_valid", 32'(cmd_valid), 32'd0);
        check("t7_code",  32'(cmd_code),  32'd0);
        check("t7_arg",   32'(cmd_arg),   32'd0);
        check("t7_errs",  {29'd0, frame_err, chk_err, overrun}, 32'd0);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_pkt(8'h12, 8'h34, 8'h26);
        check("t7_post_valid", 32'(cmd_valid), 32'd1);
        check("t7_post_code",  32'(cmd_code),  32'h12);
        check("t7_post_arg",   32'(cmd_arg),   32'h34);
        consume("t7_drop");

        check("frame_total", 32'(n_frame), 32'd1);
        check("ovr_total",   32'(n_ovr),   32'd1);
        check("pulse_excl",  32'(excl_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
